grf_wport_arb: RTL and testbench
================================

Name: grf_wport_arb

Overview:
Two-requester arbiter that shares the single GRF write port (wEn/wA/wD/pc) between the pipeline writeback stage (requester 0) and a multi-cycle unit such as mult/div (requester 1). It grants one write per cycle with fixed priority to requester 0, plus a starvation guard for requester 1. It drives the GRF write port from a registered output stage and exposes the in-flight write for forwarding. It sits directly in front of the GRF write inputs.

Parameters:
STARVE_LIM, 4, number of consecutive cycles requester 1 may be valid and denied before it is forcibly granted (legal range 1..15).
DW, 32, data and pc width.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
hold  input  1  1 = grant nothing this cycle; inputs stay pending.
req0Valid  input  1  requester 0 has a write.
req0A  input  5  requester 0 destination register.
req0D  input  DW  requester 0 write data.
req0Pc  input  DW  requester 0 instruction pc (for the GRF write trace).
req0Ready  output  1  requester 0 write accepted this cycle.
req1Valid, req1A, req1D, req1Pc, req1Ready: same as requester 0, for requester 1.
wEn  output  1  GRF write enable.
wA  output  5  GRF write address.
wD  output  DW  GRF write data.
pc  output  DW  pc forwarded to GRF.
fwdValid  output  1  equals wEn; write in flight this cycle, not yet visible on GRF reads.
starved  output  1  FSM is in FORCE1.

Behaviour:
- Reset (reset=0, asynchronous): wEn=0, wA=0, wD=0, pc=0, starve counter=0, FSM=PRIO0. req0Ready and req1Ready are 0 while reset=0. Reset asserted mid-transfer discards the pending output-stage write; GRF sees no write.
- Handshake: a transfer happens when reqNValid=1 and reqNReady=1 in the same cycle. reqNReady is combinational from the valids, hold and FSM state, and is 1 only when reqNValid=1. At most one ready is 1 per cycle. Requesters hold valid, A, D and Pc stable until ready.
- FSM PRIO0: if hold, no grant. Otherwise requester 0 wins if valid, else requester 1 if valid. Cycles where req1Valid=1 and requester 1 is denied, including denials due to hold, increment the starve counter. When the counter reaches STARVE_LIM, go to FORCE1. A requester 1 grant clears the counter.
- FSM FORCE1: if hold, no grant and stay. Otherwise grant requester 1, clear the counter, return to PRIO0, and deny requester 0 this cycle. If req1Valid drops while in FORCE1 (protocol violation), return to PRIO0 with the counter cleared and apply normal PRIO0 arbitration in that cycle.
- Latency: a grant in cycle T registers the write. wEn/wA/wD/pc are valid in cycle T+1 and the GRF updates at the end of T+1. No grant in T means wEn=0 in T+1; wA/wD/pc hold their last values.
- Address 0: the transfer is accepted (ready=1) but wEn stays 0 in T+1. This consumes the grant and clears the starve counter if requester 1 was granted.
- Same-address writes by both requesters are committed in grant order. The later grant overwrites the earlier one.
- Counter is 4 bits and saturates at 15. It never wraps.

Test Plan:
- Reset: drive reset=0 mid-cycle with req0Valid=1 -> wEn=0 and both readies 0 immediately (asynchronous); after reset=1, first grant appears with wEn=1 one cycle later.
- Single requester: req0 with A=5, D=0x1234, Pc=0x3000 for one cycle -> req0Ready=1 that cycle; next cycle wEn=1, wA=5, wD=0x1234, pc=0x3000; the cycle after, wEn=0.
- Contention: both valid continuously, STARVE_LIM=4 -> requester 0 granted 4 cycles, starved=1 in cycle 5 with requester 1 granted, then requester 0 again; the pattern repeats every 5 cycles.
- Hold: both valid and hold=1 for 6 cycles -> no readies, wEn=0; counter saturates the FSM in FORCE1; first cycle with hold=0 grants requester 1.
- Address 0: req1 with A=0, D=0xFFFF -> req1Ready=1, next cycle wEn=0, counter cleared.
- Same address: req0 and req1 both target A=8, D0=0x11, D1=0x22, both valid -> wD=0x11 in T+1 and 0x22 in T+2; final register value is 0x22.

Source files
------------

// File: rtl/grf_wport_arb.sv
// rtl/grf_wport_arb.sv - two-requester arbiter for the shared GRF write port with starvation guard
module grf_wport_arb #(
  parameter int unsigned STARVE_LIM = 4,
  parameter int unsigned DW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hold,
  input  logic          req0Valid,
  input  logic [4:0]    req0A,
  input  logic [DW-1:0] req0D,
  input  logic [DW-1:0] req0Pc,
  output logic          req0Ready,
  input  logic          req1Valid,
  input  logic [4:0]    req1A,
  input  logic [DW-1:0] req1D,
  input  logic [DW-1:0] req1Pc,
  output logic          req1Ready,
  output logic          wEn,
  output logic [4:0]    wA,
  output logic [DW-1:0] wD,
  output logic [DW-1:0] pc,
  output logic          fwdValid,
  output logic          starved
);

  typedef enum logic {
    PRIO0  = 1'b0,
    FORCE1 = 1'b1
  } state_e;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_d;
  logic          force_act;
  logic          gnt0;
  logic          gnt1;
  logic [4:0]    wa_d;
  logic [DW-1:0] wd_d;
  logic [DW-1:0] pc_d;
  logic          wr_d;
  logic          wen_q;
  logic [4:0]    wa_q;
  logic [DW-1:0] wd_q;
  logic [DW-1:0] pc_q;

  // Grant decision: requester 0 has priority unless requester 1 is being forced through.
  // A forced state whose requester has dropped valid falls back to normal priority.
  always_comb begin
    force_act = (state_q == FORCE1) && req1Valid;
    gnt1      = reset && !hold && req1Valid && (force_act || !req0Valid);
    gnt0      = reset && !hold && req0Valid && !force_act;
    cnt_d     = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    wa_d      = gnt1 ? req1A  : req0A;
    wd_d      = gnt1 ? req1D  : req0D;
    pc_d      = gnt1 ? req1Pc : req0Pc;
    wr_d      = (gnt0 || gnt1) && (wa_d != 5'd0);
  end

  assign req0Ready = gnt0;
  assign req1Ready = gnt1;

  // Starvation FSM: count denied requester-1 cycles, force a grant once the limit is reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PRIO0;
      cnt_q   <= 4'd0;
    end else if (gnt1) begin
      state_q <= PRIO0;
      cnt_q   <= 4'd0;
    end else if ((state_q == FORCE1) && !req1Valid) begin
      state_q <= PRIO0;
      cnt_q   <= 4'd0;
    end else if (req1Valid) begin
      cnt_q <= cnt_d;
      if (cnt_d >= LIM) begin
        state_q <= FORCE1;
      end
    end
  end

  // Registered write stage; address-0 grants are swallowed and leave the last write visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wen_q <= 1'b0;
      wa_q  <= 5'd0;
      wd_q  <= '0;
      pc_q  <= '0;
    end else begin
      wen_q <= wr_d;
      if (wr_d) begin
        wa_q <= wa_d;
        wd_q <= wd_d;
        pc_q <= pc_d;
      end
    end
  end

  assign wEn      = wen_q;
  assign fwdValid = wen_q;
  assign wA       = wa_q;
  assign wD       = wd_q;
  assign pc       = pc_q;
  assign starved  = (state_q == FORCE1);

endmodule

// File: tb/tb_grf_wport_arb.sv
// tb/tb_grf_wport_arb.sv - self-checking bench for grf_wport_arb
module tb_grf_wport_arb;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hold = 1'b0;
  logic        req0Valid = 1'b0;
  logic [4:0]  req0A = 5'd0;
  logic [31:0] req0D = 32'd0;
  logic [31:0] req0Pc = 32'd0;
  logic        req0Ready;
  logic        req1Valid = 1'b0;
  logic [4:0]  req1A = 5'd0;
  logic [31:0] req1D = 32'd0;
  logic [31:0] req1Pc = 32'd0;
  logic        req1Ready;
  logic        wEn;
  logic [4:0]  wA;
  logic [31:0] wD;
  logic [31:0] pc;
  logic        fwdValid;
  logic        starved;

  int total = 0;
  int bad = 0;

  logic [31:0] grf [32];

  grf_wport_arb #(.STARVE_LIM(LIM), .DW(32)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req0Valid(req0Valid), .req0A(req0A), .req0D(req0D), .req0Pc(req0Pc), .req0Ready(req0Ready),
    .req1Valid(req1Valid), .req1A(req1A), .req1D(req1D), .req1Pc(req1Pc), .req1Ready(req1Ready),
    .wEn(wEn), .wA(wA), .wD(wD), .pc(pc), .fwdValid(fwdValid), .starved(starved)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural register file as the GRF would see it
  always @(posedge clk) begin
    if (reset && wEn) grf[wA] <= wD;
  end

  // Reference model: who should win this cycle and what the write port shows next cycle
  int          m_wait = 0;
  bit          m_force = 0;
  bit          m_wen = 0;
  logic [4:0]  m_wa = 0;
  logic [31:0] m_wd = 0;
  logic [31:0] m_pc = 0;

  always @(negedge clk) begin
    bit e0, e1;
    logic [4:0] a;
    if (!reset) begin
      m_wait = 0; m_force = 0; m_wen = 0; m_wa = 0; m_wd = 0; m_pc = 0;
      check("rst_ready0", {31'd0, req0Ready}, 32'd0);
      check("rst_ready1", {31'd0, req1Ready}, 32'd0);
      check("rst_wen", {31'd0, wEn}, 32'd0);
      check("rst_wd", wD, 32'd0);
    end else begin
      check("m_wen", {31'd0, wEn}, {31'd0, m_wen});
      check("m_fwd", {31'd0, fwdValid}, {31'd0, m_wen});
      check("m_wa", {27'd0, wA}, {27'd0, m_wa});
      check("m_wd", wD, m_wd);
      check("m_pc", pc, m_pc);
      check("m_starved", {31'd0, starved}, {31'd0, m_force});
      if (m_force && !req1Valid) begin
        m_force = 0;
        m_wait = 0;
      end
      e1 = !hold && req1Valid && (m_force || !req0Valid);
      e0 = !hold && req0Valid && !e1;
      check("m_ready0", {31'd0, req0Ready}, {31'd0, e0});
      check("m_ready1", {31'd0, req1Ready}, {31'd0, e1});
      m_wen = 0;
      if (e0 || e1) begin
        a = e1 ? req1A : req0A;
        if (a != 0) begin
          m_wen = 1;
          m_wa = a;
          m_wd = e1 ? req1D : req0D;
          m_pc = e1 ? req1Pc : req0Pc;
        end
      end
      if (e1) begin
        m_wait = 0;
        m_force = 0;
      end else if (req1Valid) begin
        m_wait = (m_wait >= 15) ? 15 : m_wait + 1;
        if (m_wait >= LIM) m_force = 1;
      end
    end
  end

  initial begin
    logic [9:0] pat;
    logic [4:0] pat5;
    repeat (2) tick();
    check("pre_starved", {31'd0, starved}, 32'd0);
    reset = 1'b1;

    // single requester 0 write
    req0Valid = 1; req0A = 5; req0D = 32'h1234; req0Pc = 32'h3000;
    #3 check("single_ready0", {31'd0, req0Ready}, 32'd1);
    tick(); req0Valid = 0;
    #3 check("single_wen", {31'd0, wEn}, 32'd1);
    check("single_wa", {27'd0, wA}, 32'd5);
    check("single_wd", wD, 32'h1234);
    check("single_pc", pc, 32'h3000);
    tick();
    #3 check("single_wen_off", {31'd0, wEn}, 32'd0);
    check("single_wa_held", {27'd0, wA}, 32'd5);

    // asynchronous reset while a write is in flight
    tick();
    req0Valid = 1; req0A = 7; req0D = 32'hAA; req0Pc = 32'h44;
    tick();
    #2 reset = 0;
    #1 check("arst_wen", {31'd0, wEn}, 32'd0);
    check("arst_ready0", {31'd0, req0Ready}, 32'd0);
    check("arst_wd", wD, 32'd0);
    tick();
    tick(); reset = 1;
    #3 check("arst_ready0_after", {31'd0, req0Ready}, 32'd1);
    tick(); req0Valid = 0;
    #3 check("arst_wen_after", {31'd0, wEn}, 32'd1);
    check("arst_wa_after", {27'd0, wA}, 32'd7);
    tick();

    // continuous contention: requester 1 forced every fifth cycle
    req0Valid = 1; req0A = 1; req0D = 32'h101; req0Pc = 32'h1000;
    req1Valid = 1; req1A = 2; req1D = 32'h202; req1Pc = 32'h2000;
    pat = 10'b1000010000;
    for (int i = 0; i < 10; i++) begin
      #3 check("cont_ready1", {31'd0, req1Ready}, {31'd0, pat[i]});
      check("cont_ready0", {31'd0, req0Ready}, {31'd0, ~pat[i]});
      check("cont_starved", {31'd0, starved}, {31'd0, pat[i]});
      tick();
    end
    req0Valid = 0; req1Valid = 0;
    tick();

    // hold with both pending drives the FSM into the forced state
    hold = 1;
    req0Valid = 1; req0A = 3; req0D = 32'h33; req0Pc = 32'h3300;
    req1Valid = 1; req1A = 4; req1D = 32'h44; req1Pc = 32'h4400;
    for (int i = 0; i < 6; i++) begin
      #3 check("hold_ready0", {31'd0, req0Ready}, 32'd0);
      check("hold_ready1", {31'd0, req1Ready}, 32'd0);
      check("hold_starved", {31'd0, starved}, (i >= 4) ? 32'd1 : 32'd0);
      tick();
    end
    hold = 0;
    #3 check("unhold_ready1", {31'd0, req1Ready}, 32'd1);
    check("unhold_ready0", {31'd0, req0Ready}, 32'd0);
    tick(); req1Valid = 0;
    #3 check("unhold_wen", {31'd0, wEn}, 32'd1);
    check("unhold_wa", {27'd0, wA}, 32'd4);
    check("unhold_wd", wD, 32'h44);
    check("unhold_starved", {31'd0, starved}, 32'd0);
    check("unhold_ready0_next", {31'd0, req0Ready}, 32'd1);
    tick(); req0Valid = 0;
    tick();

    // address 0 grant clears the starve counter without writing
    req0Valid = 1; req0A = 1; req0D = 32'h101; req0Pc = 32'h1000;
    req1Valid = 1; req1A = 2; req1D = 32'h202; req1Pc = 32'h2000;
    repeat (3) tick();
    req0Valid = 0; req1A = 0; req1D = 32'hFFFF; req1Pc = 32'h5000;
    #3 check("a0_ready1", {31'd0, req1Ready}, 32'd1);
    tick(); req1Valid = 0;
    #3 check("a0_wen", {31'd0, wEn}, 32'd0);
    check("a0_wa_held", {27'd0, wA}, 32'd1);
    tick();
    req0Valid = 1; req1Valid = 1; req1A = 2; req1D = 32'h202; req1Pc = 32'h2000;
    pat5 = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      #3 check("a0_cnt_ready1", {31'd0, req1Ready}, {31'd0, pat5[i]});
      tick();
    end
    req0Valid = 0; req1Valid = 0;
    tick();

    // same address from both requesters commits in grant order
    req0Valid = 1; req0A = 8; req0D = 32'h11; req0Pc = 32'h500;
    req1Valid = 1; req1A = 8; req1D = 32'h22; req1Pc = 32'h600;
    #3 check("same_ready0", {31'd0, req0Ready}, 32'd1);
    tick(); req0Valid = 0;
    #3 check("same_ready1", {31'd0, req1Ready}, 32'd1);
    check("same_wd0", wD, 32'h11);
    check("same_wa0", {27'd0, wA}, 32'd8);
    tick(); req1Valid = 0;
    #3 check("same_wd1", wD, 32'h22);
    check("same_pc1", pc, 32'h600);
    tick();
    #3 check("same_grf8", grf[8], 32'h22);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
